dram_arbiter: RTL and testbench

Shares the single SDRAM controller request port between three requesters: the bootloader (write-only image copy), the processor instruction fetch, and the processor data port. Sits in `top` between `bootloader`/`dlx_processor` and the SDRAM controller that drives the `dram_*` pins. It keeps exactly one transaction outstanding and returns a one-cycle acknowledge, carrying read data where applicable, to the granted requester.

---
 rtl/dram_arb_pkg.sv | 27 ++
 rtl/dram_arb_rr.sv | 47 ++++
 rtl/dram_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_dram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb_pkg
// Description : Shared types and default widths for the SDRAM request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

    localparam int DRAM_ARB_DATA_WIDTH     = 32;
    localparam int DRAM_ARB_ADDR_WIDTH     = 22;
    localparam int DRAM_ARB_TIMEOUT_CYCLES = 1023;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_BOOT  = 2'd0,
        REQ_INSTR = 2'd1,
        REQ_DATA  = 2'd2
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/dram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb_rr
// Description : Two-way round-robin selector between instruction fetch and
//               data port. Holds the last-grant pointer (reset: instr, so data
//               wins the first tie). The pointer moves only on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arb_rr
    import dram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_req,
    input  logic       data_req,
    input  logic       advance,
    output logic [1:0] grant_id
);

    logic    last_data_q;
    logic    last_data_d;
    req_id_e w_grant;

    // Pick the requester not granted last on a tie; a lone requester always wins.
    always_comb begin
        w_grant = REQ_INSTR;
        if (instr_req && data_req) begin
            w_grant = last_data_q ? REQ_INSTR : REQ_DATA;
        end else if (data_req) begin
            w_grant = REQ_DATA;
        end
        last_data_d = advance ? (w_grant == REQ_DATA) : last_data_q;
    end

    // Last-grant pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end

    assign grant_id = w_grant;

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Shares one SDRAM controller request port between bootloader,
//               instruction fetch and data port. One transaction outstanding,
//               one-cycle registered acknowledge to the granted requester.
//               Optional watchdog compiled in with DRAM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DRAM_ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DRAM_ARB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DRAM_ARB_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_mode,
    input  logic                  boot_req,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    input  logic [DATA_WIDTH-1:0] boot_wr_data,
    output logic                  boot_ack,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_ack,
    output logic [DATA_WIDTH-1:0] instr_rd_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wr_data,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rd_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_accept,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  err_timeout
);

    state_e                state_q, state_d;
    req_id_e               gnt_q, gnt_d;
    logic                  txn_we_q, txn_we_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic                  boot_ack_q, boot_ack_d;
    logic                  instr_ack_q, instr_ack_d;
    logic                  data_ack_q, data_ack_d;
    logic [DATA_WIDTH-1:0] instr_rd_data_q, instr_rd_data_d;
    logic [DATA_WIDTH-1:0] data_rd_data_q, data_rd_data_d;

    logic                  w_start;
    req_id_e               w_win;
    logic                  w_rd_done;
    logic                  w_timeout;
    logic                  w_expired;
    logic [1:0]            w_rr_grant;
    logic [DATA_WIDTH-1:0] w_rd_value;

    dram_arb_rr u_rr (
        .clk       (clk),
        .rst       (rst),
        .instr_req (instr_req),
        .data_req  (data_req),
        .advance   (w_start && (w_win != REQ_BOOT)),
        .grant_id  (w_rr_grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitration in IDLE, completion/timeout tracking afterwards.
    always_comb begin
        state_d   = state_q;
        w_start   = 1'b0;
        w_win     = REQ_BOOT;
        w_rd_done = 1'b0;
        w_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_mode) begin
                    w_start = boot_req;
                end else if (instr_req || data_req) begin
                    w_start = 1'b1;
                    w_win   = req_id_e'(w_rr_grant);
                end
                if (w_start) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_accept) begin
                    state_d = txn_we_q ? RESP : WAIT_RD;
                end else if (w_expired) begin
                    state_d   = RESP;
                    w_timeout = 1'b1;
                end
            end
            WAIT_RD: begin
                if (mem_rd_valid) begin
                    state_d   = RESP;
                    w_rd_done = 1'b1;
                end else if (w_expired) begin
                    state_d   = RESP;
                    w_timeout = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timed-out reads return zero rather than stale controller data.
    assign w_rd_value = w_rd_done ? mem_rd_data : '0;

    // Output next-values: latch the winner's fields at grant, ack on RESP entry.
    always_comb begin
        gnt_d           = gnt_q;
        txn_we_d        = txn_we_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wr_data_d   = mem_wr_data_q;
        boot_ack_d      = 1'b0;
        instr_ack_d     = 1'b0;
        data_ack_d      = 1'b0;
        instr_rd_data_d = instr_rd_data_q;
        data_rd_data_d  = data_rd_data_q;

        if (w_start) begin
            gnt_d     = w_win;
            mem_req_d = 1'b1;
            case (w_win)
                REQ_BOOT: begin
                    mem_we_d      = 1'b1;
                    mem_addr_d    = boot_addr;
                    mem_wr_data_d = boot_wr_data;
                end
                REQ_INSTR: begin
                    mem_we_d      = 1'b0;
                    mem_addr_d    = instr_addr;
                    mem_wr_data_d = '0;
                end
                default: begin
                    mem_we_d      = data_we;
                    mem_addr_d    = data_addr;
                    mem_wr_data_d = data_wr_data;
                end
            endcase
            txn_we_d = mem_we_d;
        end

        if ((state_q == ISSUE) && (state_d != ISSUE)) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
        end

        if ((state_d == RESP) && (state_q != RESP)) begin
            case (gnt_q)
                REQ_BOOT:  boot_ack_d = 1'b1;
                REQ_INSTR: begin
                    instr_ack_d = 1'b1;
                    if (!txn_we_q) instr_rd_data_d = w_rd_value;
                end
                default: begin
                    data_ack_d = 1'b1;
                    if (!txn_we_q) data_rd_data_d = w_rd_value;
                end
            endcase
        end
    end

    // Registered outputs and latched transaction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q           <= REQ_BOOT;
            txn_we_q        <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_data_q   <= '0;
            boot_ack_q      <= 1'b0;
            instr_ack_q     <= 1'b0;
            data_ack_q      <= 1'b0;
            instr_rd_data_q <= '0;
            data_rd_data_q  <= '0;
        end else begin
            gnt_q           <= gnt_d;
            txn_we_q        <= txn_we_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wr_data_q   <= mem_wr_data_d;
            boot_ack_q      <= boot_ack_d;
            instr_ack_q     <= instr_ack_d;
            data_ack_q      <= data_ack_d;
            instr_rd_data_q <= instr_rd_data_d;
            data_rd_data_q  <= data_rd_data_d;
        end
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;

    // Watchdog count restarts on every state change, runs while waiting on memory.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ISSUE) || (state_q == WAIT_RD)) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
        err_d = err_q | w_timeout;
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign w_expired   = ((state_q == ISSUE) || (state_q == WAIT_RD)) &&
                         (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;
`else
    logic w_unused_cfg;

    assign w_expired    = 1'b0;
    assign err_timeout  = 1'b0;
    assign w_unused_cfg = w_timeout | (TIMEOUT_CYCLES != 0);
`endif

    assign boot_ack      = boot_ack_q;
    assign instr_ack     = instr_ack_q;
    assign data_ack      = data_ack_q;
    assign instr_rd_data = instr_rd_data_q;
    assign data_rd_data  = data_rd_data_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wr_data   = mem_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench for dram_arbiter. Expected acknowledges
//               are queued when a request is driven and popped on each ack.
//               Build with DRAM_ARB_TIMEOUT_EN to exercise the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

    localparam int DW = 32;
    localparam int AW = 22;
    localparam int ID_NONE  = 0;
    localparam int ID_BOOT  = 1;
    localparam int ID_INSTR = 2;
    localparam int ID_DATA  = 3;

    logic          clk, rst;
    logic          boot_mode, boot_req, boot_ack;
    logic [AW-1:0] boot_addr;
    logic [DW-1:0] boot_wr_data;
    logic          instr_req, instr_ack;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_rd_data;
    logic          data_req, data_we, data_ack;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wr_data, data_rd_data;
    logic          mem_req, mem_we, mem_accept, mem_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          err_timeout;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_data_hold = 32'h0;

    dram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .boot_mode(boot_mode),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wr_data(boot_wr_data), .boot_ack(boot_ack),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_rd_data(instr_rd_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_ack(data_ack), .data_rd_data(data_rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_accept(mem_accept), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ack_id();
        int n;
        n = int'(boot_ack) + int'(instr_ack) + int'(data_ack);
        if (n > 1) return 9;
        if (boot_ack) return ID_BOOT;
        if (instr_ack) return ID_INSTR;
        if (data_ack) return ID_DATA;
        return ID_NONE;
    endfunction

    task automatic push_exp(input int id, input logic [31:0] d);
        exp_t e;
        e.id = id;
        e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic wait_mem_req(input int max, output bit ok);
        ok = mem_req;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            ok = mem_req;
        end
    endtask

    task automatic wait_ack(input int max, output int id, output int waited);
        waited = 0;
        id = ack_id();
        while (id == ID_NONE && waited < max) begin
            tick();
            waited++;
            id = ack_id();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; boot_mode = 0; boot_req = 0; boot_addr = '0; boot_wr_data = '0;
        instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0; data_addr = '0;
        data_wr_data = '0; mem_accept = 0; mem_rd_valid = 0; mem_rd_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if ({boot_ack, instr_ack, data_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {boot_ack, instr_ack, data_ack}); end
        n_cmp++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_req_we: got %b want 00", {mem_req, mem_we}); end
        n_cmp++; if (mem_addr !== '0 || mem_wr_data !== '0) begin n_fail++; $display("FAIL reset_mem_fields: got addr %h data %h want 0", mem_addr, mem_wr_data); end
        n_cmp++; if (instr_rd_data !== '0 || data_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h %h want 0", instr_rd_data, data_rd_data); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_boot;
        exp_t e;
        bit   bad;
        boot_mode = 1; boot_req = 1; boot_addr = 22'h10; boot_wr_data = 32'hDEADBEEF;
        instr_req = 1; instr_addr = 22'h3FF;
        push_exp(ID_BOOT, 32'h0);
        tick();
        boot_addr = 22'h2AA; boot_wr_data = 32'h0;
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wr_data} !== {1'b1, 1'b1, 22'h10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL boot_issue: got req %b we %b addr %h data %h want 1 1 10 deadbeef", mem_req, mem_we, mem_addr, mem_wr_data); end
        mem_accept = 1;
        tick();
        mem_accept = 0;
        e = sb.pop_front();
        n_cmp++; if (ack_id() !== e.id) begin n_fail++; $display("FAIL boot_ack: got id %0d want %0d", ack_id(), e.id); end
        boot_req = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_req || ack_id() != ID_NONE) bad = 1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL boot_blocks_instr: got activity %b want 0", bad); end
        instr_req = 0; boot_mode = 0;
        tick();
    endtask

    task automatic test_instr_read;
        exp_t e;
        int   pulses;
        instr_req = 1; instr_addr = 22'h40;
        push_exp(ID_INSTR, 32'h20100005);
        tick();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 22'h40}) begin
            n_fail++; $display("FAIL instr_issue: got req %b we %b addr %h want 1 0 40", mem_req, mem_we, mem_addr); end
        mem_accept = 1; mem_rd_valid = 1; mem_rd_data = 32'hBAD0BAD0;
        tick();
        mem_accept = 0; mem_rd_valid = 0;
        n_cmp++; if ({mem_req, ack_id() != ID_NONE} !== 2'b00) begin n_fail++; $display("FAIL instr_wait1: got req %b ack %0d want 0 0", mem_req, ack_id()); end
        tick();
        n_cmp++; if (ack_id() !== ID_NONE) begin n_fail++; $display("FAIL instr_stray_valid: got ack %0d want 0", ack_id()); end
        tick();
        mem_rd_valid = 1; mem_rd_data = 32'h20100005;
        tick();
        mem_rd_valid = 0;
        e = sb.pop_front();
        n_cmp++; if (ack_id() !== e.id) begin n_fail++; $display("FAIL instr_ack: got id %0d want %0d", ack_id(), e.id); end
        n_cmp++; if (instr_rd_data !== e.rdata) begin n_fail++; $display("FAIL instr_rd_data: got %h want %h", instr_rd_data, e.rdata); end
        instr_req = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instr_ack) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL instr_single_pulse: got %0d extra pulses want 0", pulses); end
        n_cmp++; if (instr_rd_data !== 32'h20100005) begin n_fail++; $display("FAIL instr_rd_hold: got %h want 20100005", instr_rd_data); end
    endtask

    task automatic test_round_robin;
        exp_t e;
        bit   ok;
        logic [AW-1:0] want_addr;
        rst = 1; tick(); tick(); rst = 0;
        instr_req = 1; instr_addr = 22'h100;
        data_req = 1; data_we = 0; data_addr = 22'h200;
        push_exp(ID_DATA, 32'hC0DE0000);
        push_exp(ID_INSTR, 32'hC0DE0001);
        push_exp(ID_DATA, 32'hC0DE0002);
        push_exp(ID_INSTR, 32'hC0DE0003);
        for (int k = 0; k < 4; k++) begin
            wait_mem_req(6, ok);
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_req_%0d: got no mem_req want 1", k); end
            e = sb.pop_front();
            want_addr = (e.id == ID_DATA) ? 22'h200 : 22'h100;
            n_cmp++; if (mem_addr !== want_addr) begin n_fail++; $display("FAIL rr_grant_%0d: got addr %h want %h", k, mem_addr, want_addr); end
            mem_accept = 1;
            tick();
            mem_accept = 0; mem_rd_valid = 1; mem_rd_data = e.rdata;
            tick();
            mem_rd_valid = 0;
            n_cmp++; if (ack_id() !== e.id) begin n_fail++; $display("FAIL rr_ack_%0d: got id %0d want %0d", k, ack_id(), e.id); end
            if (e.id == ID_DATA) begin
                exp_data_hold = e.rdata;
                n_cmp++; if (data_rd_data !== e.rdata) begin n_fail++; $display("FAIL rr_data_rd_%0d: got %h want %h", k, data_rd_data, e.rdata); end
            end else begin
                n_cmp++; if (instr_rd_data !== e.rdata) begin n_fail++; $display("FAIL rr_instr_rd_%0d: got %h want %h", k, instr_rd_data, e.rdata); end
            end
        end
        instr_req = 0; data_req = 0;
        tick(); tick();
    endtask

    task automatic test_data_write_stall;
        exp_t e;
        data_req = 1; data_we = 1; data_addr = 22'h123; data_wr_data = 32'hA5A5A5A5;
        push_exp(ID_DATA, exp_data_hold);
        tick();
        data_addr = 22'h3FFFFF; data_wr_data = 32'h0; data_we = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wr_data} !== {1'b1, 1'b1, 22'h123, 32'hA5A5A5A5} || ack_id() != ID_NONE) begin
                n_fail++; $display("FAIL wr_stall_%0d: got req %b we %b addr %h data %h ack %0d want 1 1 123 a5a5a5a5 0", i, mem_req, mem_we, mem_addr, mem_wr_data, ack_id()); end
            if (i == 5) mem_accept = 1;
            tick();
        end
        mem_accept = 0;
        e = sb.pop_front();
        n_cmp++; if (ack_id() !== e.id) begin n_fail++; $display("FAIL wr_ack: got id %0d want %0d", ack_id(), e.id); end
        n_cmp++; if (data_rd_data !== e.rdata) begin n_fail++; $display("FAIL wr_rd_hold: got %h want %h", data_rd_data, e.rdata); end
        data_req = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   ok;
        bit   bad;
        instr_req = 1; instr_addr = 22'h77;
        tick();
        mem_accept = 1;
        tick();
        mem_accept = 0; rst = 1; instr_req = 0;
        tick();
        rst = 0;
        n_cmp++; if ({mem_req, ack_id() != ID_NONE} !== 2'b00) begin n_fail++; $display("FAIL rstmid_abort: got req %b ack %0d want 0 0", mem_req, ack_id()); end
        mem_rd_valid = 1; mem_rd_data = 32'hFFFF0000;
        tick();
        mem_rd_valid = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (ack_id() != ID_NONE || mem_req) bad = 1;
            tick();
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got activity %b want 0", bad); end
        instr_req = 1; instr_addr = 22'h55;
        push_exp(ID_INSTR, 32'h12345678);
        wait_mem_req(4, ok);
        n_cmp++; if ({ok, mem_addr} !== {1'b1, 22'h55}) begin n_fail++; $display("FAIL rstmid_reissue: got req %b addr %h want 1 55", ok, mem_addr); end
        mem_accept = 1;
        tick();
        mem_accept = 0; mem_rd_valid = 1; mem_rd_data = 32'h12345678;
        tick();
        mem_rd_valid = 0;
        e = sb.pop_front();
        n_cmp++; if (ack_id() !== e.id || instr_rd_data !== e.rdata) begin
            n_fail++; $display("FAIL rstmid_read: got id %0d data %h want %0d %h", ack_id(), instr_rd_data, e.id, e.rdata); end
        instr_req = 0;
        tick();
    endtask

`ifdef DRAM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        exp_t e;
        bit   ok;
        int   id;
        int   waited;
        data_req = 1; data_we = 0; data_addr = 22'h99;
        push_exp(ID_DATA, 32'h0);
        wait_mem_req(4, ok);
        mem_accept = 1;
        tick();
        mem_accept = 0;
        wait_ack(20, id, waited);
        e = sb.pop_front();
        n_cmp++; if (id !== e.id || waited !== 8) begin n_fail++; $display("FAIL tmo_ack: got id %0d after %0d want %0d after 8", id, waited, e.id); end
        n_cmp++; if (data_rd_data !== e.rdata) begin n_fail++; $display("FAIL tmo_rd_data: got %h want %h", data_rd_data, e.rdata); end
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err_set: got %b want 1", err_timeout); end
        data_req = 0;
        repeat (5) tick();
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", err_timeout); end
        rst = 1; tick(); rst = 0;
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err_timeout); end
    endtask
`else
    task automatic test_no_timeout;
        exp_t e;
        bit   ok;
        int   id;
        int   waited;
        data_req = 1; data_we = 0; data_addr = 22'h99;
        push_exp(ID_DATA, 32'h0BADF00D);
        wait_mem_req(4, ok);
        mem_accept = 1;
        tick();
        mem_accept = 0;
        wait_ack(30, id, waited);
        n_cmp++; if (id !== ID_NONE || err_timeout !== 1'b0) begin n_fail++; $display("FAIL notmo_wait: got ack %0d err %b want 0 0", id, err_timeout); end
        mem_rd_valid = 1; mem_rd_data = 32'h0BADF00D;
        tick();
        mem_rd_valid = 0;
        e = sb.pop_front();
        n_cmp++; if (ack_id() !== e.id || data_rd_data !== e.rdata) begin
            n_fail++; $display("FAIL notmo_read: got id %0d data %h want %0d %h", ack_id(), data_rd_data, e.id, e.rdata); end
        data_req = 0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_instr_read();
        test_round_robin();
        test_data_write_stall();
        test_reset_mid();
`ifdef DRAM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
